// File: rtl/mac_sequencer.sv
// mac_sequencer
// Sequences operand pairs from a valid/ready source into an external
// multiply-accumulator and returns one dot product per row of a job.
// A job is `rows` dot products, each built from `len` operand pairs. Before
// every row the accumulator is cleared with a one-cycle `retro` strobe.
//
// Ports
//   clk        : clock, all logic on the rising edge
//   rst        : synchronous reset, active low
//   start      : one-cycle job request, honoured only while idle
//   len, rows  : pairs per dot product / dot products per job (latched on start)
//   in_valid   : source presents an operand pair
//   in_a, in_b : operand pair
//   in_ready   : pair accepted this cycle (only while running a row)
//   A, B       : registered operands to the accumulator
//   enable     : registered accumulate strobe
//   retro      : registered accumulator-clear strobe
//   acc        : accumulator value
//   res_valid  : res_data holds a finished dot product
//   res_data   : captured dot product (accumulator value, modulo 2^DW)
//   res_ready  : sink consumes the result
//   busy       : high in every state except idle
//   done       : one-cycle pulse after the last result of a job is consumed
module mac_sequencer #(
  parameter int DW = 8,
  parameter int LW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [LW-1:0] len,
  input  logic [LW-1:0] rows,
  input  logic          in_valid,
  input  logic [DW-1:0] in_a,
  input  logic [DW-1:0] in_b,
  output logic          in_ready,
  output logic [DW-1:0] A,
  output logic [DW-1:0] B,
  output logic          enable,
  output logic          retro,
  input  logic [DW-1:0] acc,
  output logic          res_valid,
  output logic [DW-1:0] res_data,
  input  logic          res_ready,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    FLUSH,
    RESULT
  } state_t;

  localparam logic [LW-1:0] ONE = LW'(1);

  state_t        state, state_nx;
  logic [LW-1:0] len_q, len_nx;
  logic [LW-1:0] rows_q, rows_nx;
  logic [LW-1:0] elem_cnt, elem_nx;
  logic [LW-1:0] row_cnt, row_nx;
  logic          flush_cnt, flush_nx;
  logic [DW-1:0] a_nx, b_nx;
  logic          enable_nx, retro_nx;
  logic          res_valid_nx;
  logic [DW-1:0] res_data_nx;
  logic          done_nx;

  assign in_ready = (state == RUN);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      len_q     <= '0;
      rows_q    <= '0;
      elem_cnt  <= '0;
      row_cnt   <= '0;
      flush_cnt <= 1'b0;
      A         <= '0;
      B         <= '0;
      enable    <= 1'b0;
      retro     <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_nx;
      len_q     <= len_nx;
      rows_q    <= rows_nx;
      elem_cnt  <= elem_nx;
      row_cnt   <= row_nx;
      flush_cnt <= flush_nx;
      A         <= a_nx;
      B         <= b_nx;
      enable    <= enable_nx;
      retro     <= retro_nx;
      res_valid <= res_valid_nx;
      res_data  <= res_data_nx;
      done      <= done_nx;
    end
  end

  // retro and enable are registered, so they are raised on the transition
  // into the state in which they must be visible: retro is high exactly
  // during the CLEAR cycle, enable during the cycle after a handshake.
  always_comb begin
    state_nx     = state;
    len_nx       = len_q;
    rows_nx      = rows_q;
    elem_nx      = elem_cnt;
    row_nx       = row_cnt;
    flush_nx     = flush_cnt;
    a_nx         = A;
    b_nx         = B;
    enable_nx    = 1'b0;
    retro_nx     = 1'b0;
    res_valid_nx = res_valid;
    res_data_nx  = res_data;
    done_nx      = 1'b0;

    unique case (state)
      IDLE: begin
        if (start && (len != '0) && (rows != '0)) begin
          len_nx   = len;
          rows_nx  = rows;
          elem_nx  = '0;
          row_nx   = '0;
          retro_nx = 1'b1;
          state_nx = CLEAR;
        end
      end

      CLEAR: begin
        state_nx = RUN;
      end

      RUN: begin
        if (in_valid) begin
          a_nx      = in_a;
          b_nx      = in_b;
          enable_nx = 1'b1;
          elem_nx   = elem_cnt + ONE;
          if (elem_cnt == len_q - ONE) begin
            flush_nx = 1'b0;
            state_nx = FLUSH;
          end
        end
      end

      // First FLUSH cycle: the final enable is in flight. Second cycle: acc
      // already contains the final product, so it is safe to capture.
      FLUSH: begin
        flush_nx = 1'b1;
        if (flush_cnt) begin
          res_data_nx  = acc;
          res_valid_nx = 1'b1;
          state_nx     = RESULT;
        end
      end

      RESULT: begin
        if (res_ready) begin
          res_valid_nx = 1'b0;
          row_nx       = row_cnt + ONE;
          if (row_cnt == rows_q - ONE) begin
            done_nx  = 1'b1;
            state_nx = IDLE;
          end else begin
            elem_nx  = '0;
            retro_nx = 1'b1;
            state_nx = CLEAR;
          end
        end
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mac_sequencer.sv
// tb_mac_sequencer
// Directed bench for mac_sequencer with a behavioural accumulator attached to
// A/B/enable/retro/acc. Expected dot products are hand-computed constants.
module tb_mac_sequencer;

  localparam int DW = 8;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] len = '0;
  logic [LW-1:0] rows = '0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_a = '0;
  logic [DW-1:0] in_b = '0;
  logic          res_ready = 1'b0;
  logic          in_ready;
  logic [DW-1:0] A;
  logic [DW-1:0] B;
  logic          enable;
  logic          retro;
  logic          res_valid;
  logic [DW-1:0] res_data;
  logic          busy;
  logic          done;

  // External accumulator; starts with a stale value that must never leak.
  logic [DW-1:0] acc = 8'h5A;

  int vectors = 0;
  int miscompares = 0;
  int retro_cnt = 0;
  int en_cnt = 0;
  int overlap = 0;
  int rb = 0;
  int eb = 0;

  mac_sequencer #(.DW(DW), .LW(LW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .len      (len),
    .rows     (rows),
    .in_valid (in_valid),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_ready (in_ready),
    .A        (A),
    .B        (B),
    .enable   (enable),
    .retro    (retro),
    .acc      (acc),
    .res_valid(res_valid),
    .res_data (res_data),
    .res_ready(res_ready),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (retro) acc <= '0;
    else if (enable) acc <= acc + A * B;
  end

  always @(posedge clk) begin
    #2;
    if (retro) retro_cnt++;
    if (enable) en_cnt++;
    if (enable && retro) overlap++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_A"}, A, 0);
    check({tag, "_B"}, B, 0);
    check({tag, "_enable"}, enable, 0);
    check({tag, "_retro"}, retro, 0);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_res_valid"}, res_valid, 0);
    check({tag, "_res_data"}, res_data, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  task automatic start_job(input logic [LW-1:0] l, input logic [LW-1:0] r, input string tag);
    rb = retro_cnt;
    eb = en_cnt;
    @(negedge clk);
    start = 1'b1;
    len = l;
    rows = r;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_clear_retro"}, retro, 1);
    check({tag, "_clear_enable"}, enable, 0);
    check({tag, "_clear_busy"}, busy, 1);
    check({tag, "_clear_in_ready"}, in_ready, 0);
    check({tag, "_retro_before_enable"}, en_cnt - eb, 0);
  endtask

  task automatic send_pair(input logic [DW-1:0] a, input logic [DW-1:0] b, input int gap);
    int n;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("handshake_timeout", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic get_result(input logic [DW-1:0] exp, input int hold, input bit last, input string tag);
    int n;
    n = 0;
    while (!res_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_res_valid"}, res_valid, 1);
    check({tag, "_res_data"}, res_data, exp);
    repeat (hold) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, res_valid, 1);
      check({tag, "_hold_data"}, res_data, exp);
      check({tag, "_hold_in_ready"}, in_ready, 0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check({tag, "_valid_cleared"}, res_valid, 0);
    if (last) begin
      check({tag, "_done_pulse"}, done, 1);
      check({tag, "_idle_busy"}, busy, 0);
      @(negedge clk);
      check({tag, "_done_single"}, done, 0);
    end else begin
      check({tag, "_next_row_retro"}, retro, 1);
      check({tag, "_no_done"}, done, 0);
    end
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;

    // len=3 rows=1, back to back: 2+12+30 = 44
    start_job(4'd3, 4'd1, "dot3");
    send_pair(8'd1, 8'd2, 0);
    send_pair(8'd3, 8'd4, 0);
    send_pair(8'd5, 8'd6, 0);
    get_result(8'd44, 0, 1'b1, "dot3");
    check("dot3_enable_cycles", en_cnt - eb, 3);
    check("dot3_retro_pulses", retro_cnt - rb, 1);

    // len=2 rows=2: 6+20 = 26, 1+49 = 50; start while busy is ignored
    start_job(4'd2, 4'd2, "rows2");
    send_pair(8'd2, 8'd3, 0);
    start = 1'b1;
    len = 4'd5;
    rows = 4'd3;
    @(negedge clk);
    start = 1'b0;
    check("busy_start_retro", retro, 0);
    check("busy_start_in_ready", in_ready, 1);
    check("busy_start_busy", busy, 1);
    send_pair(8'd4, 8'd5, 0);
    get_result(8'd26, 0, 1'b0, "rows2_r0");
    send_pair(8'd1, 8'd1, 0);
    send_pair(8'd7, 8'd7, 0);
    get_result(8'd50, 0, 1'b1, "rows2_r1");
    check("rows2_retro_pulses", retro_cnt - rb, 2);
    check("rows2_enable_cycles", en_cnt - eb, 4);

    // gaps on in_valid, res_ready late by 5 cycles: 4+9+16 = 29
    start_job(4'd3, 4'd1, "gaps");
    send_pair(8'd2, 8'd2, int'($urandom_range(1, 3)));
    send_pair(8'd3, 8'd3, int'($urandom_range(0, 3)));
    send_pair(8'd4, 8'd4, int'($urandom_range(1, 3)));
    get_result(8'd29, 5, 1'b1, "gaps");
    check("gaps_enable_cycles", en_cnt - eb, 3);

    // 256 + 3 wraps to 3
    start_job(4'd2, 4'd1, "wrap");
    send_pair(8'd16, 8'd16, 0);
    send_pair(8'd1, 8'd3, 0);
    get_result(8'd3, 0, 1'b1, "wrap");

    // zero-length and zero-row starts are ignored
    rb = retro_cnt;
    @(negedge clk);
    start = 1'b1;
    len = 4'd0;
    rows = 4'd1;
    @(negedge clk);
    start = 1'b0;
    check("len0_busy", busy, 0);
    check("len0_retro", retro, 0);
    check("len0_in_ready", in_ready, 0);
    start = 1'b1;
    len = 4'd2;
    rows = 4'd0;
    @(negedge clk);
    start = 1'b0;
    check("rows0_busy", busy, 0);
    check("rows0_retro_pulses", retro_cnt - rb, 0);

    // reset in the middle of a len=4 job, then a clean job of (1,1)x4
    start_job(4'd4, 4'd1, "rstjob");
    send_pair(8'd3, 8'd3, 0);
    send_pair(8'd2, 8'd2, 0);
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("midjob_reset");
    rst = 1'b1;
    start_job(4'd4, 4'd1, "after_rst");
    send_pair(8'd1, 8'd1, 0);
    send_pair(8'd1, 8'd1, 0);
    send_pair(8'd1, 8'd1, 0);
    send_pair(8'd1, 8'd1, 0);
    get_result(8'd4, 0, 1'b1, "after_rst");

    check("enable_retro_overlap", overlap, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mac_sequencer.md
MAC_SEQUENCER -- requirements
Module: mac_sequencer

Interface
REQ-001 Parameter DW, default 8: operand and result width; equals the width of global_pkg data_t.
REQ-002 Parameter LW, default 4: width of the length and row-count inputs.
REQ-003 Port clk, input, 1: single clock; all logic on the posedge.
REQ-004 Port rst, input, 1: reset, synchronous and active-low.
REQ-005 Port start, input, 1: one-cycle request to begin a job; sampled only in IDLE.
REQ-006 Port len, input, LW: element pairs per dot product; captured on an accepted start.
REQ-007 Port rows, input, LW: dot products per job; captured on an accepted start.
REQ-008 Port in_valid, input, 1: source presents an operand pair.
REQ-009 Port in_a, input, DW: operand A of the pair.
REQ-010 Port in_b, input, DW: operand B of the pair.
REQ-011 Port in_ready, output, 1: sequencer accepts a pair this cycle.
REQ-012 Port A, output, DW: registered operand to the accumulator.
REQ-013 Port B, output, DW: registered operand to the accumulator.
REQ-014 Port enable, output, 1: registered accumulate strobe to the accumulator.
REQ-015 Port retro, output, 1: registered accumulator-clear strobe.
REQ-016 Port acc, input, DW: accumulator output value.
REQ-017 Port res_valid, output, 1: res_data holds a finished dot product.
REQ-018 Port res_data, output, DW: captured dot-product result.
REQ-019 Port res_ready, input, 1: sink consumes the result.
REQ-020 Port busy, output, 1: high in every state except IDLE.
REQ-021 Port done, output, 1: one-cycle pulse after the last result of a job is consumed.

Function
REQ-022 FSM states: IDLE, CLEAR, RUN, FLUSH, RESULT.
REQ-023 IDLE: start=1 with len!=0 and rows!=0 latches len and rows, clears the element and row counters, and goes to CLEAR; any other start is ignored and the FSM stays in IDLE.
REQ-024 CLEAR: retro=1 and enable=0 for exactly one cycle, then go to RUN.
REQ-025 RUN: in_ready=1; a handshake (in_valid & in_ready) registers A<=in_a, B<=in_b, enable<=1 for the next cycle and increments the element counter.
REQ-026 RUN cycles with no handshake drive enable=0; A and B hold their values.
REQ-027 The len-th handshake moves the FSM to FLUSH; in_ready is 0 in every state except RUN.
REQ-028 FLUSH lasts exactly 2 cycles so the last enable is absorbed into acc; on exit, res_data<=acc and res_valid<=1, and the FSM goes to RESULT.
REQ-029 RESULT: res_valid and res_data hold until res_ready=1.
REQ-030 On res_ready=1 in RESULT: res_valid clears next cycle and the row counter increments.
REQ-031 After res_ready, if rows are remaining: go to CLEAR.
REQ-032 After res_ready on the last row: done=1 for one cycle and go to IDLE.
REQ-033 enable and retro are never asserted in the same cycle.
REQ-034 Arithmetic: the result is the accumulator's value, i.e. the sum of A*B modulo 2^DW; the sequencer does no saturation.
REQ-035 start in any state other than IDLE is ignored; len and rows stay stable for the whole job.
REQ-036 Input pairs are never lost or duplicated under arbitrary in_valid gaps or any res_ready delay.

Reset
REQ-037 rst=0 at a clock edge, in any state, forces IDLE, clears both counters, and sets every output to 0: A, B, enable, retro, in_ready, res_valid, res_data, busy and done.
REQ-038 After reset, the first job starts with CLEAR, so a stale accumulator value never leaks into a result.

Verification
REQ-039 DW=8, len=3, rows=1, pairs (1,2),(3,4),(5,6) sent back to back -> exactly one retro pulse before the first enable, three enable cycles, res_data=44, done pulses after res_ready.
REQ-040 len=2, rows=2, pairs (2,3),(4,5) then (1,1),(7,7) -> results 26 then 50, with one retro pulse between the rows.
REQ-041 Random in_valid gaps and res_ready held low for 5 cycles -> res_valid=1 and res_data stable throughout; in_ready=0 outside RUN; results unchanged.
REQ-042 DW=8, len=2, pairs (16,16),(1,3) -> res_data=3 (256 wraps to 0).
REQ-043 rst=0 asserted after the second handshake of a len=4 job -> all outputs 0 next cycle; a new job with (1,1)x4 then yields res_data=4.
REQ-044 start with len=0, and separately start while busy -> no state change, no retro, in_ready unaffected.
